// File: rtl/m_or_carry_drain.sv
// Receive side of the carry-extended stochastic OR.
// Rebuilds the units lost to OR coincidence: a pending counter re-emits them
// as a serial stochastic stream, and a windowed accumulator reports the
// binary count of all units received per window of 2^NB_WIN enabled cycles.
module m_or_carry_drain #(
    parameter int NB_PEND = 4,
    parameter int NB_WIN  = 8,
    parameter int NB_CNT  = NB_WIN + 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              CLR,
    input  logic              IN_OR,
    input  logic              IN_C0,
    input  logic              IN_C1,
    output logic              OUT_S,
    output logic [NB_PEND-1:0] PEND,
    output logic              OVF,
    output logic [NB_CNT-1:0] CNT_OUT,
    output logic              CNT_VALID
);

    // Two spare bits: pending max plus three new units must not wrap.
    localparam logic [NB_PEND+1:0] PEND_MAX = {2'b00, {NB_PEND{1'b1}}};

    logic [1:0]         units;
    logic [NB_PEND+1:0] total;
    logic [NB_PEND+1:0] drain;
    logic               out_next;
    logic               sat;
    logic [NB_PEND-1:0] pend_next;

    logic [NB_WIN-1:0]  win_q;
    logic [NB_CNT-1:0]  acc_q;
    logic [NB_CNT-1:0]  acc_sum;
    logic               win_last;

    // Units this cycle are the raw bit sum; illegal carry patterns pass through.
    assign units = {1'b0, IN_OR} + {1'b0, IN_C0} + {1'b0, IN_C1};

    // Drain arithmetic: emit one unit if anything is owed, keep the rest.
    always_comb begin
        total     = {2'b00, PEND} + {{NB_PEND{1'b0}}, units};
        out_next  = (total != '0);
        drain     = total - {{(NB_PEND+1){1'b0}}, out_next};
        sat       = (drain > PEND_MAX);
        pend_next = sat ? PEND_MAX[NB_PEND-1:0] : drain[NB_PEND-1:0];
    end

    // Window bookkeeping: last slot of the window and the running sum including this cycle.
    always_comb begin
        win_last = &win_q;
        acc_sum  = acc_q + {{(NB_CNT-2){1'b0}}, units};
    end

    // Serial output, pending counter and sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            OUT_S <= 1'b0;
            PEND  <= '0;
            OVF   <= 1'b0;
        end else if (EN) begin
            OUT_S <= out_next;
            PEND  <= pend_next;
            if (sat) begin
                OVF <= 1'b1;
            end
        end else begin
            OUT_S <= 1'b0;
        end
    end

    // Window counter and accumulator; partial windows are dropped on clear.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            win_q <= '0;
            acc_q <= '0;
        end else if (EN) begin
            win_q <= win_q + 1'b1;
            acc_q <= win_last ? '0 : acc_sum;
        end
    end

    // Count result and its one-cycle valid pulse; clear keeps the last result.
    always_ff @(posedge CLK) begin
        if (RST) begin
            CNT_OUT   <= '0;
            CNT_VALID <= 1'b0;
        end else if (CLR) begin
            CNT_VALID <= 1'b0;
        end else if (EN && win_last) begin
            CNT_OUT   <= acc_sum;
            CNT_VALID <= 1'b1;
        end else begin
            CNT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_m_or_carry_drain.sv
// Scoreboard bench for m_or_carry_drain: directed scenarios followed by
// random traffic, checked against a behavioural model of owed units.
module tb_m_or_carry_drain;

    localparam int NB_PEND = 4;
    localparam int NB_WIN  = 4;
    localparam int NB_CNT  = NB_WIN + 2;
    localparam int PMAX    = (1 << NB_PEND) - 1;
    localparam int WLEN    = 1 << NB_WIN;

    logic              CLK;
    logic              RST;
    logic              EN;
    logic              CLR;
    logic              IN_OR;
    logic              IN_C0;
    logic              IN_C1;
    logic              OUT_S;
    logic [NB_PEND-1:0] PEND;
    logic              OVF;
    logic [NB_CNT-1:0] CNT_OUT;
    logic              CNT_VALID;

    m_or_carry_drain #(.NB_PEND(NB_PEND), .NB_WIN(NB_WIN), .NB_CNT(NB_CNT)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR),
        .IN_OR(IN_OR), .IN_C0(IN_C0), .IN_C1(IN_C1),
        .OUT_S(OUT_S), .PEND(PEND), .OVF(OVF),
        .CNT_OUT(CNT_OUT), .CNT_VALID(CNT_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int out_s;
        int pend;
        int ovf;
        int valid;
        int cnt;
    } exp_t;

    exp_t q_cyc[$];
    int   q_cnt[$];

    int total = 0;
    int bad   = 0;
    bit started = 0;
    bit done    = 0;

    // Behavioural model: units owed, window progress, last reported count.
    int m_owed = 0;
    int m_ovf  = 0;
    int m_wlen = 0;
    int m_wsum = 0;
    int m_cnt  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Apply one clock of stimulus and record what the DUT must show after the edge.
    task automatic step(input bit rst, input bit clr, input bit en,
                        input bit i_or, input bit i_c0, input bit i_c1);
        exp_t e;
        int   a;
        @(negedge CLK);
        RST = rst; CLR = clr; EN = en; IN_OR = i_or; IN_C0 = i_c0; IN_C1 = i_c1;
        e.out_s = 0;
        e.valid = 0;
        if (rst || clr) begin
            m_owed = 0; m_ovf = 0; m_wlen = 0; m_wsum = 0;
            if (rst) m_cnt = 0;
        end else if (en) begin
            a = int'(i_or) + int'(i_c0) + int'(i_c1);
            m_owed += a;
            if (m_owed > 0) begin
                e.out_s = 1;
                m_owed -= 1;
            end
            if (m_owed > PMAX) begin
                m_owed = PMAX;
                m_ovf  = 1;
            end
            m_wsum += a;
            m_wlen += 1;
            if (m_wlen == WLEN) begin
                m_cnt   = m_wsum;
                e.valid = 1;
                q_cnt.push_back(m_wsum);
                m_wsum = 0;
                m_wlen = 0;
            end
        end
        e.pend = m_owed;
        e.ovf  = m_ovf;
        e.cnt  = m_cnt;
        q_cyc.push_back(e);
        started = 1;
    endtask

    task automatic units_step(input bit en, input int a);
        step(1'b0, 1'b0, en, a >= 1, a >= 2, a >= 3);
    endtask

    // Monitor: after each edge compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        int   c;
        forever begin
            @(posedge CLK);
            #1;
            if (started && !done) begin
                if (q_cyc.size() == 0) begin
                    chk("cycle_queue_empty", 1, 0);
                end else begin
                    e = q_cyc.pop_front();
                    chk("OUT_S", int'(OUT_S), e.out_s);
                    chk("PEND", int'(PEND), e.pend);
                    chk("OVF", int'(OVF), e.ovf);
                    chk("CNT_VALID", int'(CNT_VALID), e.valid);
                    chk("CNT_OUT_level", int'(CNT_OUT), e.cnt);
                end
                if (CNT_VALID) begin
                    if (q_cnt.size() == 0) begin
                        chk("unexpected_cnt_valid", int'(CNT_OUT), -1);
                    end else begin
                        c = q_cnt.pop_front();
                        chk("CNT_OUT_window", int'(CNT_OUT), c);
                    end
                end
            end
        end
    end

    initial begin
        RST = 1'b1; CLR = 1'b0; EN = 1'b0; IN_OR = 1'b0; IN_C0 = 1'b0; IN_C1 = 1'b0;

        // Reset held with all inputs active, then release.
        step(1, 0, 1, 1, 1, 1);
        step(1, 0, 1, 1, 1, 1);
        units_step(1, 3);
        for (int i = 0; i < 4; i++) units_step(1, 0);

        // Single burst of three units drains over three cycles.
        step(0, 1, 1, 0, 0, 0);
        units_step(1, 3);
        for (int i = 0; i < 5; i++) units_step(1, 0);

        // Saturation: ten cycles of a=3, then drain the clamped backlog.
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) units_step(1, 3);
        for (int i = 0; i < 18; i++) units_step(1, 0);
        step(0, 1, 0, 0, 0, 0);

        // Windows of a=1 then a=3.
        for (int i = 0; i < WLEN; i++) units_step(1, 1);
        for (int i = 0; i < WLEN; i++) units_step(1, 3);
        for (int i = 0; i < 20; i++) units_step(1, 0);

        // EN toggling with a=2: window completes after 32 clocks.
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2 * WLEN; i++) units_step(i % 2 == 0, 2);
        for (int i = 0; i < 20; i++) units_step(1, 0);

        // Clear mid-window; next window counts from zero.
        for (int i = 0; i < 5; i++) units_step(1, 2);
        step(0, 1, 1, 1, 1, 1);
        for (int i = 0; i < WLEN; i++) units_step(1, 1);
        units_step(1, 0);

        // Random traffic including illegal carry patterns, clears and resets.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        end

        @(posedge CLK);
        #2;
        done = 1;
        chk("pending_cycle_expectations", q_cyc.size(), 0);
        chk("missing_cnt_valid", q_cnt.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog at %0t: got timeout expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/m_or_carry_drain.md
Name: m_or_carry_drain

Overview:
- Receive side of the carry-extended stochastic OR (OR output plus CARRY0/CARRY1).
- OR-ing N stochastic streams loses coincident ones. This block takes the per-cycle OR bit and its two carry bits and rebuilds the lost units:
  - a pending-unit counter re-emits lost ones as a single-bit stochastic stream on later cycles;
  - a windowed accumulator gives a binary count of all units received.
- Sits downstream of a cascading-OR neuron summation stage, before the next stochastic layer or a stochastic-to-binary readout.

Parameters:
- NB_PEND, 4: pending counter width; saturates at 2^NB_PEND-1.
- NB_WIN, 8: window length is 2^NB_WIN enabled cycles.
- NB_CNT, NB_WIN+2: accumulator and count output width (holds max 3*2^NB_WIN-1 … 3*2^NB_WIN).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  cycle qualifier; low freezes all state.
- CLR  input  1  synchronous clear of pending, window and accumulator; lower priority than RST.
- IN_OR  input  1  OR output bit from the upstream stage.
- IN_C0  input  1  CARRY0 (upstream count > 1).
- IN_C1  input  1  CARRY1 (upstream count > 2).
- OUT_S  output  1  re-serialised stochastic stream, registered.
- PEND  output  NB_PEND  current pending-unit count.
- OVF  output  1  sticky: pending saturated and a unit was dropped.
- CNT_OUT  output  NB_CNT  units counted in the last completed window.
- CNT_VALID  output  1  one-cycle pulse when CNT_OUT updates.

Behaviour:
- Reset (RST=1 at a clock edge) forces OUT_S=0, PEND=0, OVF=0, CNT_OUT=0, CNT_VALID=0, window counter=0, accumulator=0. RST overrides EN and CLR.
- CLR=1 (RST=0):
  - same clearing as reset, except CNT_OUT holds its value;
  - CLR wins over EN; the current input units are discarded.
- Per-cycle units: a = IN_OR + IN_C0 + IN_C1, range 0..3, plain bit sum. An illegal combination (e.g. C1 without C0) is not corrected.
- EN=1 cycle:
  - Drain: total = PEND + a. OUT_S <= (total != 0). Next pending = total - OUT_S_next, saturated at 2^NB_PEND-1.
  - Saturation: when saturation clips units, OVF <= 1. OVF stays set until RST or CLR.
  - Latency: one unit arriving with PEND=0 appears on OUT_S the next cycle.
  - Window: the window counter increments modulo 2^NB_WIN and the accumulator adds a, with no saturation needed because width is sized.
  - Window end: on the enabled cycle where the window counter = 2^NB_WIN-1:
    - CNT_OUT <= accumulator + a;
    - CNT_VALID <= 1 for exactly one cycle;
    - accumulator <= 0;
    - window counter wraps to 0.
- EN=0 cycle:
  - OUT_S <= 0, CNT_VALID <= 0.
  - PEND, accumulator, window counter and OVF hold.
  - Inputs are ignored.
- CNT_VALID is 0 in every cycle other than the one following a window end.
- Conservation: with no saturation, ones emitted on OUT_S plus PEND equal the total units received since the last clear.
- Reset mid-window: partial accumulation is discarded and no CNT_VALID is issued.

Test Plan:
- Reset: hold RST 2 cycles with IN_OR=IN_C0=IN_C1=1, EN=1 -> all outputs 0, PEND=0 throughout; after release, OUT_S=1 starting the following cycle.
- Drain: one cycle of a=3 (all inputs 1), then zeros, EN=1 -> OUT_S = 1,1,1 on the next three cycles; PEND = 2,1,0; then OUT_S=0.
- Saturation, NB_PEND=4: a=3 for 10 cycles -> PEND rises by 2 per cycle and clamps at 15 on cycle 8; OVF=1 from then on. After inputs go to 0 -> exactly 15 further ones on OUT_S; OVF stays 1 until CLR.
- Window, NB_WIN=4: a=1 every enabled cycle for 16 cycles -> CNT_VALID pulses once with CNT_OUT=16. Next window with a=3 every cycle -> CNT_OUT=48.
- EN gating, NB_WIN=4: EN toggles 1,0 with a=2 -> window completes after 32 clocks; CNT_OUT=32; OUT_S=0 on every EN=0 cycle; PEND holds across EN=0 cycles.
- Clear mid-window: after 5 cycles of a=2 (PEND=5, acc=10), assert CLR -> PEND=0, OVF=0, accumulator=0, CNT_OUT keeps its previous value, no CNT_VALID; the next window counts from zero.
